imem_loader: RTL and testbench

- Writable instruction store with a byte-stream program loader.
- The loader end fills the store: it receives a valid/ready byte stream, assembles big-endian 32-bit words and writes them at consecutive word addresses.
- The CPU end is a combinational read port, rd_address to instruction, which replaces the fixed-content instruction ROM in the single-cycle datapath.
- cpu_hold keeps the core stalled or reset until loading completes.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: writable instruction store filled from a byte stream.
// The loader end assembles big-endian 32-bit words and writes them at
// consecutive word addresses. The CPU end is a combinational read port.
// cpu_hold keeps the core stalled until a load has completed.
//
// Byte stream handshake: a byte is transferred on any posedge where
// byte_valid && byte_ready. byte_ready depends only on the FSM state, never
// on byte_valid. The source holds byte_data stable while byte_valid is high
// and byte_ready is low, and may raise or drop byte_valid on any cycle.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [31:0]       instruction,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [CNT_W-1:0]  word_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word address of the last entry; a write landing here fills the store.
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

    // Registered state.
    state_t             r_state;
    logic [1:0]         r_byte_ptr;
    logic [ADDR_W-1:0]  r_word_ptr;
    logic [CNT_W-1:0]   r_word_count;
    logic [23:0]        r_asm;
    logic               r_load_done;
    logic               r_load_error;
    logic               r_cpu_hold;
    logic [31:0]        r_mem [0:DEPTH-1];

    // Next-state values.
    state_t             w_state_nxt;
    logic [1:0]         w_byte_ptr_nxt;
    logic [ADDR_W-1:0]  w_word_ptr_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [23:0]        w_asm_nxt;
    logic               w_done_nxt;
    logic               w_error_nxt;
    logic               w_hold_nxt;

    // Transfer qualifiers.
    logic               w_ready;
    logic               w_xfer;
    logic               w_word_done;
    logic [31:0]        w_word;

    assign w_ready     = (r_state == ST_LOAD);
    assign w_xfer      = byte_valid && w_ready;
    assign w_word_done = w_xfer && (r_byte_ptr == 2'd3);
    // The 4th byte is taken straight from the input so the write lands on
    // the same edge the byte is accepted.
    assign w_word      = {r_asm, byte_data};

    // Next-state and datapath updates for the load FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_ptr_nxt = r_byte_ptr;
        w_word_ptr_nxt = r_word_ptr;
        w_count_nxt    = r_word_count;
        w_asm_nxt      = r_asm;
        w_done_nxt     = r_load_done;
        w_error_nxt    = r_load_error;
        w_hold_nxt     = r_cpu_hold;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // A new load starts from a clean slate in either state.
                if (load_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_byte_ptr_nxt = 2'd0;
                    w_word_ptr_nxt = '0;
                    w_count_nxt    = '0;
                    w_asm_nxt      = '0;
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                    w_hold_nxt     = 1'b1;
                end
            end

            ST_LOAD: begin
                // The byte is processed first so that a simultaneous
                // load_end sees the updated byte pointer.
                if (w_xfer) begin
                    w_byte_ptr_nxt = r_byte_ptr + 2'd1;
                    case (r_byte_ptr)
                        2'd0:    w_asm_nxt[23:16] = byte_data;
                        2'd1:    w_asm_nxt[15:8]  = byte_data;
                        2'd2:    w_asm_nxt[7:0]   = byte_data;
                        default: begin
                            w_asm_nxt      = '0;
                            w_word_ptr_nxt = r_word_ptr + ADDR_W'(1);
                            w_count_nxt    = r_word_count + CNT_W'(1);
                        end
                    endcase
                end

                if (w_word_done && (r_word_ptr == LAST_WORD)) begin
                    // Store full: the final word completes cleanly.
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                    w_error_nxt    = 1'b0;
                    w_hold_nxt     = 1'b0;
                end else if (load_end) begin
                    // A partial word is simply dropped and flagged.
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                    w_error_nxt    = (w_byte_ptr_nxt != 2'd0);
                    w_hold_nxt     = 1'b0;
                    w_byte_ptr_nxt = 2'd0;
                end
                // load_start is ignored while loading.
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 1'b1;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // State and control registers; reset returns to IDLE with the CPU held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_byte_ptr   <= 2'd0;
            r_word_ptr   <= '0;
            r_word_count <= '0;
            r_asm        <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_cpu_hold   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ptr   <= w_byte_ptr_nxt;
            r_word_ptr   <= w_word_ptr_nxt;
            r_word_count <= w_count_nxt;
            r_asm        <= w_asm_nxt;
            r_load_done  <= w_done_nxt;
            r_load_error <= w_error_nxt;
            r_cpu_hold   <= w_hold_nxt;
        end
    end

    // Instruction store write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (w_word_done) begin
            r_mem[r_word_ptr] <= w_word;
        end
    end

    // Read port: old contents stay visible until the write edge.
    assign instruction = r_mem[rd_address];

    assign byte_ready  = w_ready;
    assign cpu_hold    = r_cpu_hold;
    assign load_done   = r_load_done;
    assign load_error  = r_load_error;
    assign word_count  = r_word_count;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of read-back vectors plus
// hand-written sequences for early end, mid-word end, reset and restart.
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              load_start;
    logic              load_end;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] rd_address;
    logic [31:0]       instruction;
    logic              cpu_hold;
    logic              load_done;
    logic              load_error;
    logic [CNT_W-1:0]  word_count;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_end    (load_end),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .rd_address  (rd_address),
        .instruction (instruction),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .word_count  (word_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       exp;
    } rd_vec_t;

    rd_vec_t rd_tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic hold,
                                input logic done, input logic err, input logic [CNT_W-1:0] cnt);
        check({tag, ".byte_ready"}, 32'(byte_ready), 32'(rdy));
        check({tag, ".cpu_hold"},   32'(cpu_hold),   32'(hold));
        check({tag, ".load_done"},  32'(load_done),  32'(done));
        check({tag, ".load_error"}, 32'(load_error), 32'(err));
        check({tag, ".word_count"}, 32'(word_count), 32'(cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        byte_valid = 1'b1;
        byte_data  = b;
        load_end   = last;
        cycle();
        byte_valid = 1'b0;
        load_end   = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        cycle();
        load_end = 1'b0;
    endtask

    task automatic read_word(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        rd_address = a;
        #1;
        check(name, instruction, exp);
    endtask

    // Bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    // ---------------- test ----------------
    initial begin
        int gap;

        // Read-back vectors after the 128-byte fill (byte value = index).
        rd_tab[0] = '{addr: 5'd0,  exp: 32'h00010203};
        rd_tab[1] = '{addr: 5'd1,  exp: 32'h04050607};
        rd_tab[2] = '{addr: 5'd2,  exp: 32'h08090A0B};
        rd_tab[3] = '{addr: 5'd15, exp: 32'h3C3D3E3F};
        rd_tab[4] = '{addr: 5'd16, exp: 32'h40414243};
        rd_tab[5] = '{addr: 5'd31, exp: 32'h7C7D7E7F};

        reset      = 1'b0;
        load_start = 1'b0;
        load_end   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        rd_address = '0;

        repeat (3) cycle();
        check_status("reset", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        check("reset.state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        cycle();
        // load_start is the only way out of IDLE; bytes are not accepted.
        push(8'h55, 1'b0);
        check_status("idle", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

        // ---- 1: two words then load_end ----
        pulse_start();
        check_status("t1_start", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        push(8'h8C, 1'b0); push(8'h01, 1'b0); push(8'h00, 1'b0); push(8'h0E, 1'b0);
        push(8'hAC, 1'b0); push(8'h01, 1'b0); push(8'h00, 1'b0); push(8'h0D, 1'b0);
        check_status("t1_loaded", 1'b1, 1'b1, 1'b0, 1'b0, 6'd2);
        pulse_end();
        check_status("t1_done", 1'b0, 1'b0, 1'b1, 1'b0, 6'd2);
        check("t1.state", 32'(dbg_state), 32'd2);
        exp_q.push_back(32'h8C01000E);
        exp_q.push_back(32'hAC01000D);
        for (int a = 0; a < 2; a++) begin
            read_word("t1_mem", ADDR_W'(a), exp_q.pop_front());
        end

        // ---- 2: full store, 128 back-to-back bytes ----
        pulse_start();
        check_status("t2_start", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 128; i++) begin
            if (i == 127) check("t2_ready_last", 32'(byte_ready), 32'd1);
            push(8'(i), 1'b0);
        end
        check_status("t2_full", 1'b0, 1'b0, 1'b1, 1'b0, 6'd32);
        push(8'hFF, 1'b0);
        check_status("t2_extra", 1'b0, 1'b0, 1'b1, 1'b0, 6'd32);
        for (int k = 0; k < 6; k++) begin
            read_word("t2_tab", rd_tab[k].addr, rd_tab[k].exp);
        end

        // ---- 3: 6 bytes then load_end (partial word dropped) ----
        pulse_start();
        for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i), 1'b0);
        pulse_end();
        check_status("t3_done", 1'b0, 1'b0, 1'b1, 1'b1, 6'd1);
        read_word("t3_mem0", 5'd0, 32'hA0A1A2A3);
        read_word("t3_mem1", 5'd1, 32'h04050607);

        // ---- 4: gapped bytes, load_end with the 4th byte ----
        pulse_start();
        check_status("t4_start", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        push(8'h12, 1'b0);
        gap = $urandom_range(0, 3);
        repeat (gap) cycle();
        push(8'h34, 1'b0);
        gap = $urandom_range(0, 3);
        repeat (gap) cycle();
        push(8'h56, 1'b0);
        gap = $urandom_range(1, 3);
        repeat (gap) cycle();
        push(8'h78, 1'b1);
        check_status("t4_done", 1'b0, 1'b0, 1'b1, 1'b0, 6'd1);
        read_word("t4_mem0", 5'd0, 32'h12345678);

        // ---- 5: reset after 2 words plus 2 bytes ----
        pulse_start();
        for (int i = 0; i < 10; i++) push(8'hB0 + 8'(i), 1'b0);
        reset = 1'b0;
        #1;
        check_status("t5_reset", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        check("t5.state", 32'(dbg_state), 32'd0);
        read_word("t5_mem0", 5'd0, 32'hB0B1B2B3);
        read_word("t5_mem1", 5'd1, 32'hB4B5B6B7);
        read_word("t5_mem2", 5'd2, 32'h08090A0B);
        cycle();
        reset = 1'b1;
        cycle();
        pulse_start();
        push(8'hC0, 1'b0); push(8'hC1, 1'b0); push(8'hC2, 1'b0); push(8'hC3, 1'b0);
        pulse_end();
        check_status("t5_reload", 1'b0, 1'b0, 1'b1, 1'b0, 6'd1);
        read_word("t5_new0", 5'd0, 32'hC0C1C2C3);
        read_word("t5_new1", 5'd1, 32'hB4B5B6B7);

        // ---- 6: load_start during LOAD ignored; restart from DONE ----
        pulse_start();
        push(8'hD0, 1'b0); push(8'hD1, 1'b0);
        pulse_start();
        check("t6.state_load", 32'(dbg_state), 32'd1);
        push(8'hD2, 1'b0);
        // Read-during-write: old word visible until the write edge.
        rd_address = 5'd0;
        byte_valid = 1'b1;
        byte_data  = 8'hD3;
        #2;
        check("t6_old", instruction, 32'hC0C1C2C3);
        cycle();
        byte_valid = 1'b0;
        check("t6_new", instruction, 32'hD0D1D2D3);
        check_status("t6_mid", 1'b1, 1'b1, 1'b0, 1'b0, 6'd1);
        push(8'hE0, 1'b0); push(8'hE1, 1'b0); push(8'hE2, 1'b0); push(8'hE3, 1'b0);
        pulse_end();
        check_status("t6_done", 1'b0, 1'b0, 1'b1, 1'b0, 6'd2);
        read_word("t6_mem1", 5'd1, 32'hE0E1E2E3);
        pulse_start();
        check_status("t6_restart", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        pulse_end();
        check_status("t6_empty", 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
